merge_run_feeder: RTL and testbench

- Producer-side counterpart of the 16-wide merger. Reads a stream of 16-tuple words (one sorted run after another) from an upstream FWFT FIFO.
- Deals runs alternately into two output queues. Appends an all-zero terminator word after every run.
- Presents each queue through the same empty/read interface the merger consumes (data, empty flag, read strobe from merger).
- Sits between the memory loader and a MERGER_16 leaf.

---
 rtl/merge_feeder_pkg.sv | 15 +
 rtl/feeder_fifo.sv | 41 ++++
 rtl/merge_run_feeder.sv | 135 +++++++++++++
 tb/tb_merge_run_feeder.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/merge_feeder_pkg.sv
// Shared constants for the merge run feeder: FSM encoding, word geometry, queue select.
package merge_feeder_pkg;
    localparam int TUPLES_PER_WORD = 16;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_FILL = 2'd1;
    localparam logic [1:0] ST_TERM = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    // Terminator words are this bit replicated across the whole word.
    localparam logic TERM_BIT = 1'b0;
endpackage

// File: rtl/feeder_fifo.sv
// FWFT queue with synchronous reset; head reads as zero while empty.
module feeder_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_write,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_read,
    output logic [WIDTH-1:0] o_data,
    output logic             o_empty,
    output logic             o_full
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr, occ;
    logic             do_wr, do_rd;

    assign occ     = wr_ptr - rd_ptr;
    assign o_empty = (occ == '0);
    assign o_full  = (occ == (AW+1)'(DEPTH));
    assign do_wr   = i_write & ~o_full;
    assign do_rd   = i_read & ~o_empty;
    assign o_data  = o_empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (do_wr) mem[wr_ptr[AW-1:0]] <= i_data;
    end
endmodule

// File: rtl/merge_run_feeder.sv
// Deals sorted runs alternately into two terminator-delimited queues for a 16-wide merger.
// Optional: MERGE_RUN_FEEDER_TERM_CHECK_EN flags data words that would read as terminators.
module merge_run_feeder
    import merge_feeder_pkg::*;
#(
    parameter int DATA_WIDTH = 128,
    parameter int KEY_WIDTH  = 80,
    parameter int LEN_WIDTH  = 32,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                                  i_clk,
    input  logic                                  i_rst,
    input  logic                                  i_start,
    input  logic [LEN_WIDTH-1:0]                  i_run_len,
    input  logic [LEN_WIDTH-1:0]                  i_num_runs,
    input  logic [TUPLES_PER_WORD*DATA_WIDTH-1:0] i_in_fifo,
    input  logic                                  i_in_empty,
    output logic                                  o_in_read,
    output logic [TUPLES_PER_WORD*DATA_WIDTH-1:0] o_fifo_1,
    output logic                                  o_fifo_1_empty,
    input  logic                                  i_fifo_1_read,
    output logic [TUPLES_PER_WORD*DATA_WIDTH-1:0] o_fifo_2,
    output logic                                  o_fifo_2_empty,
    input  logic                                  i_fifo_2_read,
    output logic                                  o_busy,
    output logic                                  o_done,
    output logic                                  o_err
);
    localparam int WW = TUPLES_PER_WORD * DATA_WIDTH;
    localparam logic [LEN_WIDTH-1:0] ONE = 1;

    logic [1:0]           state;
    logic                 tgt, lone;
    logic [LEN_WIDTH-1:0] len_q, runs_q, word_cnt, run_cnt;
    logic                 full_a, full_b, full_tgt;
    logic                 term_wr, q_wr;
    logic [WW-1:0]        wr_data;

    assign full_tgt  = (tgt == SEL_B) ? full_b : full_a;
    assign o_in_read = (state == ST_FILL) & ~i_in_empty & ~full_tgt;
    assign term_wr   = (state == ST_TERM) & ~full_tgt;
    assign q_wr      = o_in_read | term_wr;
    assign wr_data   = (state == ST_FILL) ? i_in_fifo : {WW{TERM_BIT}};
    assign o_busy    = (state == ST_FILL) | (state == ST_TERM);
    assign o_done    = (state == ST_DONE);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= ST_IDLE;
            tgt      <= SEL_A;
            lone     <= 1'b0;
            len_q    <= '0;
            runs_q   <= '0;
            word_cnt <= '0;
            run_cnt  <= '0;
        end else begin
            case (state)
                ST_IDLE: if (i_start) begin
                    if (i_num_runs == '0) begin
                        state <= ST_DONE;
                    end else begin
                        len_q    <= i_run_len;
                        runs_q   <= i_num_runs;
                        tgt      <= SEL_A;
                        lone     <= 1'b0;
                        word_cnt <= '0;
                        run_cnt  <= '0;
                        state    <= (i_run_len == '0) ? ST_TERM : ST_FILL;
                    end
                end
                ST_FILL: if (o_in_read) begin
                    // Compare against len-1 so a maximal run length never wraps the counter.
                    if (word_cnt == len_q - ONE) state <= ST_TERM;
                    else word_cnt <= word_cnt + ONE;
                end
                ST_TERM: if (term_wr) begin
                    if (lone) begin
                        state <= ST_DONE;
                    end else begin
                        run_cnt <= run_cnt + ONE;
                        if (run_cnt + ONE == runs_q) begin
                            // Odd run count: queue B still needs an empty run to close out.
                            if (tgt == SEL_B) begin
                                state <= ST_DONE;
                            end else begin
                                tgt  <= SEL_B;
                                lone <= 1'b1;
                            end
                        end else begin
                            tgt      <= ~tgt;
                            word_cnt <= '0;
                            state    <= (len_q == '0) ? ST_TERM : ST_FILL;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef MERGE_RUN_FEEDER_TERM_CHECK_EN
    logic err_q;
    // Lowest tuple checked as key and payload halves; all-zero means the merger sees a terminator.
    always_ff @(posedge i_clk) begin
        if (i_rst) err_q <= 1'b0;
        else if (o_in_read && (i_in_fifo[KEY_WIDTH-1:0] == '0) &&
                 (i_in_fifo[DATA_WIDTH-1:KEY_WIDTH] == '0)) err_q <= 1'b1;
    end
    assign o_err = err_q;
`else
    assign o_err = 1'b0;
`endif

    feeder_fifo #(.WIDTH(WW), .DEPTH(FIFO_DEPTH)) u_fifo_a (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_write (q_wr & (tgt == SEL_A)),
        .i_data  (wr_data),
        .i_read  (i_fifo_1_read),
        .o_data  (o_fifo_1),
        .o_empty (o_fifo_1_empty),
        .o_full  (full_a)
    );

    feeder_fifo #(.WIDTH(WW), .DEPTH(FIFO_DEPTH)) u_fifo_b (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_write (q_wr & (tgt == SEL_B)),
        .i_data  (wr_data),
        .i_read  (i_fifo_2_read),
        .o_data  (o_fifo_2),
        .o_empty (o_fifo_2_empty),
        .o_full  (full_b)
    );
endmodule

// File: tb/tb_merge_run_feeder.sv
// Directed bench for merge_run_feeder: run dealing, terminators, back-pressure, reset, error flag.
module tb_merge_run_feeder;
    localparam int DW = 8;
    localparam int KW = 4;
    localparam int LW = 8;
    localparam int FD = 4;
    localparam int WW = 16 * DW;

    logic          i_clk = 1'b0;
    logic          i_rst, i_start;
    logic [LW-1:0] i_run_len, i_num_runs;
    logic [WW-1:0] i_in_fifo;
    logic          i_in_empty, o_in_read;
    logic [WW-1:0] o_fifo_1, o_fifo_2;
    logic          o_fifo_1_empty, o_fifo_2_empty;
    logic          i_fifo_1_read, i_fifo_2_read;
    logic          o_busy, o_done, o_err;

    int checks = 0;
    int errors = 0;

    logic [WW-1:0] up_mem [0:63];
    int up_wr = 0;
    int up_rd = 0;
    int rd_cnt = 0;
    int done_cnt = 0;

    always #5 i_clk = ~i_clk;

    merge_run_feeder #(.DATA_WIDTH(DW), .KEY_WIDTH(KW), .LEN_WIDTH(LW), .FIFO_DEPTH(FD)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start),
        .i_run_len(i_run_len), .i_num_runs(i_num_runs),
        .i_in_fifo(i_in_fifo), .i_in_empty(i_in_empty), .o_in_read(o_in_read),
        .o_fifo_1(o_fifo_1), .o_fifo_1_empty(o_fifo_1_empty), .i_fifo_1_read(i_fifo_1_read),
        .o_fifo_2(o_fifo_2), .o_fifo_2_empty(o_fifo_2_empty), .i_fifo_2_read(i_fifo_2_read),
        .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
    );

    // Upstream FWFT model plus event counters.
    assign i_in_fifo  = up_mem[up_rd];
    assign i_in_empty = (up_rd == up_wr);

    always @(posedge i_clk) begin
        if (o_in_read && !i_in_empty) begin
            up_rd  <= up_rd + 1;
            rd_cnt <= rd_cnt + 1;
        end
        if (o_done) done_cnt <= done_cnt + 1;
    end

    function automatic logic [WW-1:0] mk(input logic [7:0] n);
        return {16{n}};
    endfunction

    task automatic push(input logic [WW-1:0] w);
        up_mem[up_wr] = w;
        up_wr = up_wr + 1;
    endtask

    task automatic chk(input string tag, input logic [WW-1:0] got, input logic [WW-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic start_run(input logic [LW-1:0] len, input logic [LW-1:0] runs);
        @(negedge i_clk);
        i_start = 1'b1; i_run_len = len; i_num_runs = runs;
        @(negedge i_clk);
        i_start = 1'b0;
    endtask

    task automatic pop_chk(input logic sel, input logic [WW-1:0] exp, input string tag);
        int n = 0;
        @(negedge i_clk);
        while ((sel ? o_fifo_2_empty : o_fifo_1_empty) && n < 50) begin
            @(negedge i_clk);
            n++;
        end
        chk({tag, "_nonempty"}, WW'(sel ? o_fifo_2_empty : o_fifo_1_empty), '0);
        chk(tag, sel ? o_fifo_2 : o_fifo_1, exp);
        if (sel) i_fifo_2_read = 1'b1; else i_fifo_1_read = 1'b1;
        @(posedge i_clk);
        #1;
        i_fifo_1_read = 1'b0; i_fifo_2_read = 1'b0;
    endtask

    task automatic wait_done(input int base, input string tag);
        int n = 0;
        while (done_cnt == base && n < 300) begin
            @(negedge i_clk);
            n++;
        end
        chk(tag, WW'(done_cnt), WW'(base + 1));
    endtask

    initial begin
        int base, r0;
        logic [WW-1:0] zlow;
        i_rst = 1'b1; i_start = 1'b0; i_run_len = '0; i_num_runs = '0;
        i_fifo_1_read = 1'b0; i_fifo_2_read = 1'b0;
        repeat (2) @(negedge i_clk);
        chk("rst_a_empty", WW'(o_fifo_1_empty), WW'(1));
        chk("rst_b_empty", WW'(o_fifo_2_empty), WW'(1));
        chk("rst_a_head", o_fifo_1, '0);
        chk("rst_b_head", o_fifo_2, '0);
        chk("rst_busy", WW'(o_busy), '0);
        chk("rst_done", WW'(o_done), '0);
        chk("rst_err", WW'(o_err), '0);
        i_rst = 1'b0;

        // Two runs of three words.
        for (int i = 1; i <= 6; i++) push(mk(8'(i)));
        base = done_cnt; r0 = rd_cnt;
        start_run(8'd3, 8'd2);
        chk("t1_busy", WW'(o_busy), WW'(1));
        for (int i = 0; i < 50; i++) begin
            @(negedge i_clk);
            if (o_done) break;
        end
        chk("t1_done_pulse", WW'(o_done), WW'(1));
        chk("t1_busy_drop", WW'(o_busy), '0);
        @(negedge i_clk);
        chk("t1_done_single", WW'(o_done), '0);
        chk("t1_done_cnt", WW'(done_cnt), WW'(base + 1));
        chk("t1_reads", WW'(rd_cnt - r0), WW'(6));
        pop_chk(1'b0, mk(8'd1), "t1_a0");
        pop_chk(1'b0, mk(8'd2), "t1_a1");
        pop_chk(1'b0, mk(8'd3), "t1_a2");
        pop_chk(1'b0, '0, "t1_a_term");
        pop_chk(1'b1, mk(8'd4), "t1_b0");
        pop_chk(1'b1, mk(8'd5), "t1_b1");
        pop_chk(1'b1, mk(8'd6), "t1_b2");
        pop_chk(1'b1, '0, "t1_b_term");
        @(negedge i_clk);
        chk("t1_a_drained", WW'(o_fifo_1_empty), WW'(1));
        chk("t1_b_drained", WW'(o_fifo_2_empty), WW'(1));

        // Three runs of one word: B closes with a lone terminator.
        for (int i = 7; i <= 9; i++) push(mk(8'(i)));
        base = done_cnt;
        start_run(8'd1, 8'd3);
        wait_done(base, "t2_done");
        pop_chk(1'b0, mk(8'd7), "t2_a0");
        pop_chk(1'b0, '0, "t2_a_term0");
        pop_chk(1'b0, mk(8'd9), "t2_a1");
        pop_chk(1'b0, '0, "t2_a_term1");
        pop_chk(1'b1, mk(8'd8), "t2_b0");
        pop_chk(1'b1, '0, "t2_b_term0");
        pop_chk(1'b1, '0, "t2_b_lone");
        @(negedge i_clk);
        chk("t2_b_drained", WW'(o_fifo_2_empty), WW'(1));

        // Back-pressure: runs of eight into depth-four queues.
        for (int i = 10; i <= 25; i++) push(mk(8'(i)));
        base = done_cnt; r0 = rd_cnt;
        start_run(8'd8, 8'd2);
        repeat (10) @(negedge i_clk);
        chk("t3_stall_read", WW'(o_in_read), '0);
        chk("t3_stall_busy", WW'(o_busy), WW'(1));
        chk("t3_held", WW'(rd_cnt - r0), WW'(4));
        chk("t3_b_empty", WW'(o_fifo_2_empty), WW'(1));
        for (int i = 10; i <= 17; i++) pop_chk(1'b0, mk(8'(i)), "t3_a");
        pop_chk(1'b0, '0, "t3_a_term");
        for (int i = 18; i <= 25; i++) pop_chk(1'b1, mk(8'(i)), "t3_b");
        pop_chk(1'b1, '0, "t3_b_term");
        wait_done(base, "t3_done");
        chk("t3_reads", WW'(rd_cnt - r0), WW'(16));

        // Zero-length runs: terminators only, no upstream traffic.
        base = done_cnt; r0 = rd_cnt;
        start_run(8'd0, 8'd2);
        wait_done(base, "t4_done");
        chk("t4_reads", WW'(rd_cnt - r0), '0);
        pop_chk(1'b0, '0, "t4_a_term");
        pop_chk(1'b1, '0, "t4_b_term");

        // Zero runs: done the cycle after start, nothing queued.
        start_run(8'd5, 8'd0);
        chk("t4_norun_done", WW'(o_done), WW'(1));
        chk("t4_norun_a_empty", WW'(o_fifo_1_empty), WW'(1));
        chk("t4_norun_b_empty", WW'(o_fifo_2_empty), WW'(1));
        @(negedge i_clk);
        chk("t4_norun_done_low", WW'(o_done), '0);

        // Reset mid-fill with two words queued.
        push(mk(8'd26)); push(mk(8'd27));
        start_run(8'd4, 8'd1);
        repeat (5) @(negedge i_clk);
        chk("t5_a_filled", WW'(o_fifo_1_empty), '0);
        chk("t5_busy", WW'(o_busy), WW'(1));
        i_rst = 1'b1;
        @(negedge i_clk);
        chk("t5_a_flush", WW'(o_fifo_1_empty), WW'(1));
        chk("t5_b_flush", WW'(o_fifo_2_empty), WW'(1));
        chk("t5_busy_clr", WW'(o_busy), '0);
        i_rst = 1'b0;
        push(mk(8'd28));
        base = done_cnt;
        start_run(8'd1, 8'd1);
        wait_done(base, "t5_done");
        pop_chk(1'b0, mk(8'd28), "t5_a0");
        pop_chk(1'b0, '0, "t5_a_term");
        pop_chk(1'b1, '0, "t5_b_lone");

`ifdef MERGE_RUN_FEEDER_TERM_CHECK_EN
        zlow = {{15{8'h33}}, 8'h00};
        chk("t6_err_before", WW'(o_err), '0);
        push(zlow);
        base = done_cnt;
        start_run(8'd1, 8'd1);
        wait_done(base, "t6_done");
        chk("t6_err_set", WW'(o_err), WW'(1));
        pop_chk(1'b0, zlow, "t6_a_word");
        pop_chk(1'b0, '0, "t6_a_term");
        pop_chk(1'b1, '0, "t6_b_lone");
        chk("t6_err_hold", WW'(o_err), WW'(1));
        @(negedge i_clk);
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
        chk("t6_err_clr", WW'(o_err), '0);
`else
        zlow = '0;
        chk("t6_err_tied", WW'(o_err), zlow);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
